// File: rtl/fir_inverse_iir.sv
// All-pole IIR that undoes a direct-form FIR encoder:
// y[n] = x[n] - sum a[k]*y[n-1-k], one shared multiply per cycle.
module fir_inverse_iir #(
  parameter int WIDTH = 32,
  parameter int ORDER = 8,
  parameter int SCALE = 14
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ORDER*WIDTH-1:0]    coeffs,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [WIDTH-1:0]   x_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [WIDTH-1:0]   y_out,
  output logic                      overflow
);

  localparam int AW = 2*WIDTH + $clog2(ORDER) + 1;
  localparam int KW = (ORDER > 1) ? $clog2(ORDER) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(ORDER - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  logic [1:0]               state;
  logic [KW-1:0]            k;
  logic signed [AW-1:0]     acc;
  logic signed [AW-1:0]     acc_next;
  logic signed [AW-1:0]     shifted;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [WIDTH-1:0]  sat_val;
  logic                     clamp;
  logic signed [WIDTH-1:0]  hist [ORDER];
  logic signed [WIDTH-1:0]  coef [ORDER];

  for (genvar g = 0; g < ORDER; g++) begin : g_coef
    assign coef[g] = coeffs[g*WIDTH +: WIDTH];
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_OUT);

  always_comb begin
    prod     = (2*WIDTH)'(coef[k]) * (2*WIDTH)'(hist[k]);
    acc_next = acc - AW'(prod);
    shifted  = acc_next >>> SCALE;
    // Result fits only if every bit above the output sign bit matches it.
    clamp    = !((&shifted[AW-1:WIDTH-1]) || !(|shifted[AW-1:WIDTH-1]));
    if (!clamp)
      sat_val = shifted[WIDTH-1:0];
    else if (shifted[AW-1])
      sat_val = {1'b1, {(WIDTH-1){1'b0}}};
    else
      sat_val = {1'b0, {(WIDTH-1){1'b1}}};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      k        <= '0;
      acc      <= '0;
      y_out    <= '0;
      overflow <= 1'b0;
      for (int unsigned i = 0; i < ORDER; i++)
        hist[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            acc   <= AW'(x_in) <<< SCALE;
            k     <= '0;
            state <= S_MAC;
          end
        end
        S_MAC: begin
          acc <= acc_next;
          if (k == K_LAST) begin
            k     <= '0;
            y_out <= sat_val;
            state <= S_OUT;
            if (clamp)
              overflow <= 1'b1;
          end else begin
            k <= k + KW'(1);
          end
        end
        S_OUT: begin
          if (out_ready) begin
            hist[0] <= y_out;
            for (int unsigned i = 1; i < ORDER; i++)
              hist[i] <= hist[i-1];
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_inverse_iir.sv
// Self-checking bench for fir_inverse_iir: directed plan cases plus random
// coefficients/samples/backpressure against an arithmetic reference model.
module tb_fir_inverse_iir;

  localparam int W = 16;
  localparam int N = 4;
  localparam int S = 8;
  localparam longint YMAX = (longint'(1) << (W-1)) - 1;
  localparam longint YMIN = -(longint'(1) << (W-1));

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [N*W-1:0]        coeffs = '0;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic signed [W-1:0]   x_in = '0;
  logic                  out_valid;
  logic                  out_ready = 1'b0;
  logic signed [W-1:0]   y_out;
  logic                  overflow;

  int     n_cmp = 0;
  int     n_err = 0;
  longint mc [N];
  longint mh [N];
  bit     mov;
  longint cyc = 0;
  longint last_acc = 0;
  bit     prev_fast = 1'b0;

  fir_inverse_iir #(.WIDTH(W), .ORDER(N), .SCALE(S)) dut (
    .clk(clk), .reset(reset), .coeffs(coeffs),
    .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in),
    .out_valid(out_valid), .out_ready(out_ready), .y_out(y_out),
    .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic set_coefs(input longint a0, input longint a1, input longint a2, input longint a3);
    mc[0] = a0; mc[1] = a1; mc[2] = a2; mc[3] = a3;
    coeffs = {W'(a3), W'(a2), W'(a1), W'(a0)};
  endtask

  // y = floor((x*2^S - sum a[k]*y_prev[k]) / 2^S), clamped to the output range.
  function automatic longint model_step(input longint x);
    longint num;
    longint q;
    num = x * (longint'(1) << S);
    for (int i = 0; i < N; i++)
      num -= mc[i] * mh[i];
    q = num >>> S;
    if (q > YMAX) begin q = YMAX; mov = 1'b1; end
    else if (q < YMIN) begin q = YMIN; mov = 1'b1; end
    for (int i = N-1; i > 0; i--)
      mh[i] = mh[i-1];
    mh[0] = q;
    return q;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_y_out", y_out, 0);
    check("rst_overflow", overflow, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < N; i++) mh[i] = 0;
    mov = 1'b0;
    prev_fast = 1'b0;
  endtask

  // Entered and left at a negedge with the DUT expected idle.
  task automatic do_sample(input longint x, input int hold);
    longint exp_y;
    int lat;
    logic signed [W-1:0] held;
    exp_y = model_step(x);
    check("in_ready_idle", in_ready, 1);
    out_ready = (hold == 0);
    in_valid = 1'b1;
    x_in = W'(x);
    @(posedge clk);
    #1;
    if (prev_fast) check("accept_spacing", cyc - last_acc, N + 2);
    last_acc = cyc;
    prev_fast = (hold == 0);
    in_valid = 1'b0;
    x_in = W'($urandom);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!out_valid && lat < N + 1) check("in_ready_busy", in_ready, 0);
    end while (!out_valid && lat < 20);
    check("latency", lat, N + 1);
    check("y_out", y_out, exp_y);
    check("overflow", overflow, mov);
    held = y_out;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      x_in = W'($urandom);
      @(negedge clk);
      check("bp_y_stable", y_out, held);
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("post_out_valid", out_valid, 0);
    check("post_in_ready", in_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic signed [W-1:0] rx;
    bit seen;

    // Reset state and reset mid-MAC
    set_coefs(128, 0, 0, 0);
    do_reset();
    check("idle_in_ready", in_ready, 1);
    check("idle_out_valid", out_valid, 0);
    in_valid = 1'b1;
    x_in = 16'sd256;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midmac_rst_out_valid", out_valid, 0);
    check("midmac_rst_in_ready", in_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < N; i++) mh[i] = 0;
    mov = 1'b0;
    prev_fast = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < N + 4; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("midmac_no_output", seen, 0);

    // Impulse response, floor rounding, back-to-back throughput
    do_sample(256, 0);
    for (int i = 0; i < 11; i++) do_sample(0, 0);

    // Encoder round trip
    do_reset();
    do_sample(256, 0);
    do_sample(128, 0);
    do_sample(0, 0);
    do_sample(0, 0);

    // Backpressure with in_valid held high
    do_sample(300, 10);
    do_sample(-77, 0);

    // Saturation, sticky overflow, negative mirror
    set_coefs(-256, 0, 0, 0);
    do_reset();
    do_sample(20000, 0);
    do_sample(20000, 0);
    do_sample(0, 0);
    do_reset();
    do_sample(-20000, 0);
    do_sample(-20000, 0);

    // History reaches the last tap
    set_coefs(0, 0, 0, 128);
    do_reset();
    do_sample(256, 0);
    for (int i = 0; i < 8; i++) do_sample(0, 0);

    // Random coefficients, samples and backpressure
    for (int r = 0; r < 6; r++) begin
      set_coefs(longint'($urandom_range(0, 600)) - 300, longint'($urandom_range(0, 600)) - 300,
                longint'($urandom_range(0, 600)) - 300, longint'($urandom_range(0, 600)) - 300);
      do_reset();
      for (int i = 0; i < 8; i++) begin
        rx = W'($urandom);
        do_sample(rx, int'($urandom_range(0, 3)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
